// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Command-driven controller for a 4-bit up/down counter datapath. It takes
//   LOAD / UP n / DOWN n / HOLD n commands over a valid/ready handshake and
//   drives the counter's load/up_down/enable/d_in pins cycle-exactly.
//
// Parameters
//   WIDTH   counter data width (ctr_d_in, ctr_count, cmd_arg)
//   STEP_W  width of the remaining-cycle counter; n = cmd_arg[STEP_W-1:0]
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   cmd_valid     command present
//   cmd_ready     high only in IDLE (command can be accepted)
//   cmd_op        00 LOAD, 01 UP, 10 DOWN, 11 HOLD
//   cmd_arg       LOAD value, or cycle count n for UP/DOWN/HOLD
//   abort         cancels the active command (ignored in IDLE)
//   ctr_load, ctr_up_down, ctr_enable, ctr_d_in  -> counter control pins
//   ctr_count     <- counter value (used only with SEQ_SAT_EN)
//   busy          a command is executing
//   done          one-cycle pulse after normal completion
//   sat           pulses with done when a run stopped at a count limit
//
// Build option
//   SEQ_SAT_EN    when defined, RUN stops enabling the counter once it sits
//                 at its limit (all ones going up, zero going down) and
//                 reports sat with done. Undefined: counter wraps, sat = 0.

module counter_sequencer #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic             ctr_load,
  output logic             ctr_up_down,
  output logic             ctr_enable,
  output logic [WIDTH-1:0] ctr_d_in,
  input  logic [WIDTH-1:0] ctr_count,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]    load_val_q, load_val_d;
  logic                up_q, up_d;
  logic                done_q, done_d;
  logic                sat_q, sat_d;
  logic                limit_seen_q, limit_seen_d;

  logic [STEP_W-1:0]   cmd_n;
  logic                limit_now;

  assign cmd_n = STEP_W'(cmd_arg);

  // Limit detection looks at the live counter value in the direction of
  // the current run; without the option it never fires, so sat stays 0.
`ifdef SEQ_SAT_EN
  assign limit_now = (up_q && (ctr_count == {WIDTH{1'b1}})) ||
                     (!up_q && (ctr_count == {WIDTH{1'b0}}));
`else
  logic unused_count;
  assign unused_count = ^ctr_count;
  assign limit_now    = 1'b0;
`endif

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      load_val_q   <= '0;
      up_q         <= 1'b0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
      limit_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      load_val_q   <= load_val_d;
      up_q         <= up_d;
      done_q       <= done_d;
      sat_q        <= sat_d;
      limit_seen_q <= limit_seen_d;
    end
  end

  // Next-state and counter-pin decode. Outputs depend only on registered
  // state (plus the live limit check), so abort takes effect one edge later.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    load_val_d   = load_val_q;
    up_d         = up_q;
    done_d       = 1'b0;
    sat_d        = 1'b0;
    limit_seen_d = limit_seen_q;
    cmd_ready    = 1'b0;
    ctr_load     = 1'b0;
    ctr_up_down  = 1'b0;
    ctr_enable   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          up_d         = (cmd_op == OP_UP);
          limit_seen_d = 1'b0;
          remaining_d  = cmd_n;
          case (cmd_op)
            OP_LOAD: begin
              load_val_d = cmd_arg;
              state_d    = ST_LOAD;
            end
            OP_UP, OP_DOWN: begin
              if (cmd_n == '0) done_d  = 1'b1;
              else             state_d = ST_RUN;
            end
            OP_HOLD: begin
              if (cmd_n == '0) done_d  = 1'b1;
              else             state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_LOAD: begin
        ctr_load = 1'b1;
        state_d  = ST_IDLE;
        done_d   = !abort;
      end

      ST_RUN: begin
        ctr_up_down = up_q;
        // Once the limit has been seen, enable stays low for the rest of the run.
        ctr_enable  = !(limit_now || limit_seen_q);
        if (limit_now) limit_seen_d = 1'b1;
        if (abort) begin
          state_d      = ST_IDLE;
          remaining_d  = '0;
          limit_seen_d = 1'b0;
        end else if (remaining_q == STEP_W'(1)) begin
          state_d      = ST_IDLE;
          remaining_d  = '0;
          done_d       = 1'b1;
          sat_d        = limit_now || limit_seen_q;
          limit_seen_d = 1'b0;
        end else begin
          remaining_d = remaining_q - STEP_W'(1);
        end
      end

      ST_HOLD: begin
        if (abort) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (remaining_q == STEP_W'(1)) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
        end else begin
          remaining_d = remaining_q - STEP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign ctr_d_in = load_val_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Drives counter_sequencer against a small behavioural up/down counter and
//   compares all outputs cycle by cycle against a hand-computed vector table,
//   then runs a hand-written mid-run reset sequence.

module tb_counter_sequencer;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

`ifdef SEQ_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       abort;
  logic       ctr_load;
  logic       ctr_up_down;
  logic       ctr_enable;
  logic [3:0] ctr_d_in;
  logic [3:0] ctr_count = 4'd0;
  logic       busy;
  logic       done;
  logic       sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .STEP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .abort      (abort),
    .ctr_load   (ctr_load),
    .ctr_up_down(ctr_up_down),
    .ctr_enable (ctr_enable),
    .ctr_d_in   (ctr_d_in),
    .ctr_count  (ctr_count),
    .busy       (busy),
    .done       (done),
    .sat        (sat)
  );

  // Behavioural stand-in for the updown_counter; it has no reset of its own
  // so a sequencer reset leaves the count where it was.
  always_ff @(posedge clk) begin
    if (ctr_load)        ctr_count <= ctr_d_in;
    else if (ctr_enable) ctr_count <= ctr_up_down ? ctr_count + 4'd1 : ctr_count - 4'd1;
  end

  // One row: inputs applied for a cycle and the outputs expected during it.
  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] arg;
    logic       ab;
    logic       rdy, ld, en, ud;
    logic [3:0] din;
    logic       bsy, dn, st;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic v, input logic [1:0] op, input logic [3:0] arg,
                                 input logic ab, input logic rdy, input logic ld, input logic en,
                                 input logic ud, input logic [3:0] din, input logic bsy,
                                 input logic dn, input logic st, input logic [3:0] cnt);
    vec_t r;
    r.v = v; r.op = op; r.arg = arg; r.ab = ab;
    r.rdy = rdy; r.ld = ld; r.en = en; r.ud = ud; r.din = din;
    r.bsy = bsy; r.dn = dn; r.st = st; r.cnt = cnt;
    vecs.push_back(r);
  endfunction

  // Drive inputs at the falling edge so they are stable before the next rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] op,
                               input logic [3:0] arg, input logic ab);
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; cmd_arg = arg; abort = ab;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = {cmd_ready, ctr_load, ctr_enable, ctr_up_down, ctr_d_in, busy, done, sat, ctr_count};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got rdy/ld/en/ud/din/busy/done/sat/cnt=%b_%b_%b_%b_%h_%b_%b_%b_%h required %b_%b_%b_%b_%h_%b_%b_%b_%h",
               name, act[14], act[13], act[12], act[11], act[10:7], act[6], act[5], act[4], act[3:0],
               exp[14], exp[13], exp[12], exp[11], exp[10:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  initial begin
    logic [3:0] c26, c27, c28, c29, en_sat;
    logic [3:0] start_cnt, exp_cnt;

    // Expected counts for LOAD 0xE then UP 4, depending on saturation.
    c26    = 4'hF;
    c27    = SAT_MODE ? 4'hF : 4'h0;
    c28    = SAT_MODE ? 4'hF : 4'h1;
    c29    = SAT_MODE ? 4'hF : 4'h2;
    en_sat = SAT_MODE ? 4'h0 : 4'h1;

    //      v op       arg  ab  rdy ld en ud din  bsy dn st cnt
    addVec(0, OP_LOAD, 4'h0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0); // reset state
    addVec(1, OP_LOAD, 4'h7, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 1, 0, 0, 4'h7, 1, 0, 0, 4'h0); // LOAD cycle
    addVec(1, OP_UP,   4'h4, 0,  1, 0, 0, 0, 4'h7, 0, 1, 0, 4'h7); // done, accept UP 4
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 1, 4'h7, 1, 0, 0, 4'h7);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 1, 4'h7, 1, 0, 0, 4'h8);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 1, 4'h7, 1, 0, 0, 4'h9);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 1, 4'h7, 1, 0, 0, 4'hA);
    addVec(0, OP_LOAD, 4'h0, 0,  1, 0, 0, 0, 4'h7, 0, 1, 0, 4'hB); // UP 4 done
    addVec(1, OP_DOWN, 4'h3, 0,  1, 0, 0, 0, 4'h7, 0, 0, 0, 4'hB);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 0, 4'h7, 1, 0, 0, 4'hB);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 0, 4'h7, 1, 0, 0, 4'hA);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 0, 4'h7, 1, 0, 0, 4'h9);
    addVec(1, OP_HOLD, 4'h2, 0,  1, 0, 0, 0, 4'h7, 0, 1, 0, 4'h8); // DOWN done
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 0, 0, 4'h7, 1, 0, 0, 4'h8);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 0, 0, 4'h7, 1, 0, 0, 4'h8);
    addVec(1, OP_UP,   4'h0, 0,  1, 0, 0, 0, 4'h7, 0, 1, 0, 4'h8); // HOLD done, UP 0
    addVec(0, OP_LOAD, 4'h0, 0,  1, 0, 0, 0, 4'h7, 0, 1, 0, 4'h8); // UP 0 done
    addVec(1, OP_UP,   4'h5, 0,  1, 0, 0, 0, 4'h7, 0, 0, 0, 4'h8);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 1, 4'h7, 1, 0, 0, 4'h8);
    addVec(0, OP_LOAD, 4'h0, 1,  0, 0, 1, 1, 4'h7, 1, 0, 0, 4'h9); // abort 2nd cycle
    addVec(0, OP_LOAD, 4'h0, 0,  1, 0, 0, 0, 4'h7, 0, 0, 0, 4'hA); // no done
    addVec(1, OP_LOAD, 4'hE, 1,  1, 0, 0, 0, 4'h7, 0, 0, 0, 4'hA); // abort ignored in IDLE
    addVec(0, OP_LOAD, 4'h0, 0,  0, 1, 0, 0, 4'hE, 1, 0, 0, 4'hA);
    addVec(1, OP_UP,   4'h4, 0,  1, 0, 0, 0, 4'hE, 0, 1, 0, 4'hE);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, 1, 1, 4'hE, 1, 0, 0, 4'hE);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, en_sat[0], 1, 4'hE, 1, 0, 0, c26);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, en_sat[0], 1, 4'hE, 1, 0, 0, c27);
    addVec(0, OP_LOAD, 4'h0, 0,  0, 0, en_sat[0], 1, 4'hE, 1, 0, 0, c28);
    addVec(0, OP_LOAD, 4'h0, 0,  1, 0, 0, 0, 4'hE, 0, 1, SAT_MODE, c29);
    addVec(1, OP_HOLD, 4'h1, 0,  1, 0, 0, 0, 4'hE, 0, 0, 0, c29);
    addVec(0, OP_LOAD, 4'h0, 1,  0, 0, 0, 0, 4'hE, 1, 0, 0, c29); // abort in final cycle
    addVec(0, OP_LOAD, 4'h0, 0,  1, 0, 0, 0, 4'hE, 0, 0, 0, c29); // abort wins, no done

    // Two-cycle reset before the table.
    applyStimulus(1, 0, OP_LOAD, 4'h0, 0);
    applyStimulus(1, 0, OP_LOAD, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].v, vecs[i].op, vecs[i].arg, vecs[i].ab);
      checkOutput($sformatf("vec%0d", i),
                  {vecs[i].rdy, vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].din,
                   vecs[i].bsy, vecs[i].dn, vecs[i].st, vecs[i].cnt});
    end

    // Reset in the third cycle of DOWN 6: that cycle still counts, then
    // everything returns to reset values and the counter freezes.
    start_cnt = c29;
    applyStimulus(0, 1, OP_DOWN, 4'h6, 0);
    applyStimulus(0, 0, OP_LOAD, 4'h0, 0);
    checkOutput("rst_run1", {1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0, start_cnt});
    applyStimulus(0, 0, OP_LOAD, 4'h0, 0);
    checkOutput("rst_run2", {1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0, start_cnt - 4'd1});
    applyStimulus(1, 1, OP_UP, 4'h3, 1);
    checkOutput("rst_run3", {1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0, start_cnt - 4'd2});
    exp_cnt = start_cnt - 4'd3;
    applyStimulus(0, 0, OP_LOAD, 4'h0, 0);
    checkOutput("rst_state", {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, exp_cnt});
    applyStimulus(0, 0, OP_LOAD, 4'h0, 0);
    checkOutput("rst_frozen", {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, exp_cnt});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
